// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with registered read ports, write-first
// forwarding, optional hard-wired zero entry and a post-reset clear sweep.
//
// state   | meaning
// S_CLEAR | sweeping clr_addr over every entry writing 0; requests ignored, busy=1
// S_READY | normal operation; reads and writes accepted
module regfile_2r1w #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd0_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic              rd0_valid,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_valid,
    output logic              busy
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              ready;
    logic              wr_accept;
    logic [DATA_W-1:0] rd0_next, rd1_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            S_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == LAST_ADDR) state_d = S_READY;
            end
            S_READY: state_d = S_READY;
            default: state_d = S_CLEAR;
        endcase
    end

    assign ready     = (state_q == S_READY);
    assign busy      = ~ready;
    assign wr_accept = ready && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    // Storage has no reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[clr_addr_q] <= '0;
        end else if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Zero-register override wins over forwarding, forwarding over the array.
    assign rd0_next = ((ZERO_REG != 0) && (rd0_addr == '0)) ? '0 :
                      (wr_accept && (wr_addr == rd0_addr))  ? wr_data : mem[rd0_addr];
    assign rd1_next = ((ZERO_REG != 0) && (rd1_addr == '0)) ? '0 :
                      (wr_accept && (wr_addr == rd1_addr))  ? wr_data : mem[rd1_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_data  <= '0;
            rd0_valid <= 1'b0;
            rd1_data  <= '0;
            rd1_valid <= 1'b0;
        end else begin
            rd0_valid <= ready && rd0_en;
            rd1_valid <= ready && rd1_en;
            if (ready && rd0_en) rd0_data <= rd0_next;
            if (ready && rd1_en) rd1_data <= rd1_next;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: one instance without and one with the
// zero register, driven by the same directed vectors.
module tb_regfile_2r1w;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd0_en, rd1_en;
    logic [1:0] rd0_addr, rd1_addr;

    logic [7:0] rd0_data, rd1_data, rd0_data_z, rd1_data_z;
    logic       rd0_valid, rd1_valid, rd0_valid_z, rd1_valid_z;
    logic       busy, busy_z;

    int n_vec = 0;
    int n_err = 0;
    bit ready = 1'b0;

    // Queue index: 0 = dut rd0, 1 = dut rd1, 2 = dut_z rd0, 3 = dut_z rd1
    logic [7:0] exp_q [4][$];
    string      port_name [4] = '{"dut.rd0", "dut.rd1", "dut_z.rd0", "dut_z.rd1"};

    always #5 clk = ~clk;

    regfile_2r1w #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_valid(rd0_valid),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
        .busy(busy)
    );

    regfile_2r1w #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data_z), .rd0_valid(rd0_valid_z),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data_z), .rd1_valid(rd1_valid_z),
        .busy(busy_z)
    );

    // Monitor: every valid strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic       vld [4];
        logic [7:0] dat [4];
        logic [7:0] e;
        vld = '{rd0_valid, rd1_valid, rd0_valid_z, rd1_valid_z};
        dat = '{rd0_data, rd1_data, rd0_data_z, rd1_data_z};
        if (rst_n === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                if (vld[k] !== 1'b0) begin
                    n_vec++;
                    if (exp_q[k].size() == 0) begin
                        n_err++;
                        $display("FAIL %s unexpected valid: got valid=%b data=%02h, required no valid",
                                 port_name[k], vld[k], dat[k]);
                    end else begin
                        e = exp_q[k].pop_front();
                        if (dat[k] !== e) begin
                            n_err++;
                            $display("FAIL %s read data: got %02h, required %02h", port_name[k], dat[k], e);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, required %02h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " dut.rd0_data"},    rd0_data,    8'h00);
        check({tag, " dut.rd1_data"},    rd1_data,    8'h00);
        check({tag, " dut.rd0_valid"},   {7'd0, rd0_valid},   8'h00);
        check({tag, " dut.rd1_valid"},   {7'd0, rd1_valid},   8'h00);
        check({tag, " dut.busy"},        {7'd0, busy},        8'h01);
        check({tag, " dut_z.rd0_data"},  rd0_data_z,  8'h00);
        check({tag, " dut_z.rd1_data"},  rd1_data_z,  8'h00);
        check({tag, " dut_z.busy"},      {7'd0, busy_z},      8'h01);
    endtask

    // Called at a negedge: drive one edge's request and push expectations.
    task automatic cycle(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                         input logic r0, input logic [1:0] a0, input logic [7:0] e0, input logic [7:0] e0z,
                         input logic r1, input logic [1:0] a1, input logic [7:0] e1, input logic [7:0] e1z);
        wr_en = we;  wr_addr = wa;  wr_data = wd;
        rd0_en = r0; rd0_addr = a0;
        rd1_en = r1; rd1_addr = a1;
        if (ready && r0) begin exp_q[0].push_back(e0); exp_q[2].push_back(e0z); end
        if (ready && r1) begin exp_q[1].push_back(e1); exp_q[3].push_back(e1z); end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00);
    endtask

    // Release reset at a negedge and follow the 4-edge sweep.
    task automatic release_and_sweep(input string tag);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("%s busy after edge %0d", tag, i), {7'd0, busy},   (i < 4) ? 8'h01 : 8'h00);
            check($sformatf("%s busy_z after edge %0d", tag, i), {7'd0, busy_z}, (i < 4) ? 8'h01 : 8'h00);
        end
        ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wr_en = 0; wr_addr = '0; wr_data = '0;
        rd0_en = 0; rd0_addr = '0; rd1_en = 0; rd1_addr = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");

        // Requests held through the sweep must be ignored.
        wr_en = 1; wr_addr = 2'd3; wr_data = 8'h77;
        rd0_en = 1; rd0_addr = 2'd3;
        release_and_sweep("por");

        //    we wa     wd     r0 a0     e0     e0z    r1 a1     e1     e1z
        cycle(0, 2'd0, 8'h00, 1, 2'd0, 8'h00, 8'h00, 1, 2'd1, 8'h00, 8'h00);
        cycle(0, 2'd0, 8'h00, 1, 2'd2, 8'h00, 8'h00, 1, 2'd3, 8'h00, 8'h00);
        cycle(1, 2'd2, 8'hA5, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00);
        cycle(0, 2'd0, 8'h00, 1, 2'd2, 8'hA5, 8'hA5, 1, 2'd2, 8'hA5, 8'hA5);
        cycle(1, 2'd1, 8'h3C, 1, 2'd1, 8'h3C, 8'h3C, 1, 2'd3, 8'h00, 8'h00);
        cycle(0, 2'd0, 8'h00, 1, 2'd1, 8'h3C, 8'h3C, 1, 2'd2, 8'hA5, 8'hA5);
        cycle(1, 2'd0, 8'hFF, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00);
        cycle(0, 2'd0, 8'h00, 1, 2'd0, 8'hFF, 8'h00, 1, 2'd0, 8'hFF, 8'h00);
        cycle(1, 2'd0, 8'h11, 1, 2'd0, 8'h11, 8'h00, 1, 2'd1, 8'h3C, 8'h3C);
        cycle(1, 2'd1, 8'hFF, 0, 2'd0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 8'h00);
        cycle(0, 2'd0, 8'h00, 1, 2'd1, 8'hFF, 8'hFF, 1, 2'd1, 8'hFF, 8'hFF);
        cycle(1, 2'd3, 8'h77, 1, 2'd3, 8'h77, 8'h77, 1, 2'd3, 8'h77, 8'h77);
        idle();

        // Valid drops without a request while data holds.
        check("hold dut.rd0_valid",  {7'd0, rd0_valid},   8'h00);
        check("hold dut.rd0_data",   rd0_data,            8'h77);
        check("hold dut_z.rd1_data", rd1_data_z,          8'h77);

        // Reset pulse while READY.
        #2 rst_n = 1'b0;
        ready = 1'b0;
        #1 check_reset_outputs("mid");
        @(negedge clk);
        release_and_sweep("mid");

        cycle(0, 2'd0, 8'h00, 1, 2'd2, 8'h00, 8'h00, 1, 2'd1, 8'h00, 8'h00);
        cycle(0, 2'd0, 8'h00, 1, 2'd3, 8'h00, 8'h00, 1, 2'd0, 8'h00, 8'h00);
        idle();
        idle();

        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (exp_q[k].size() != 0) begin
                n_err++;
                $display("FAIL %s missing valid: got %0d reads outstanding, required 0",
                         port_name[k], exp_q[k].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
